frame_checker_mc: RTL and testbench

Multi-channel successor of the single-stream frame checker. It observes filtered test frames on an AXIS input and keeps per-channel statistics, one channel per axis_s_id value: frames, bytes, sequence errors and bad frames. It either sinks or forwards the frames, selected by parameter. It sits behind the test-frame filter and is controlled by start/stop; statistics are read per channel through a selectable 128-bit result.

---
 rtl/frame_checker_pkg.sv | 13 +
 rtl/keep_popcount.sv | 13 +
 rtl/frame_checker_mc.sv | 154 +++++++++++++++
 tb/tb_frame_checker_mc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_checker_pkg.sv
// frame_checker_pkg: shared state encoding and result layout for frame_checker_mc.
package frame_checker_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, DRAIN} state_t;
  localparam int SEQ_WIDTH = 32;
  localparam int FRAMES_W = 32;
  localparam int BYTES_W = 48;
  localparam int SEQERR_W = 24;
  localparam int BAD_W = 24;
  localparam int FRAMES_LSB = 96;
  localparam int BYTES_LSB = 48;
  localparam int SEQERR_LSB = 24;
  localparam int BAD_LSB = 0;
endpackage

// File: rtl/keep_popcount.sv
// keep_popcount: number of set bits in an AXIS keep vector.
module keep_popcount #(
  parameter int KEEP_WIDTH = 8,
  localparam int CW = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CW-1:0]         count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) count = count + CW'(keep[i]);
  end
endmodule

// File: rtl/frame_checker_mc.sv
// frame_checker_mc: per-channel frame/byte/sequence/bad-frame statistics on an AXIS stream.
module frame_checker_mc
  import frame_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH = 3,
  parameter int SEQ_BYTE_OFFSET = 42,
  parameter int FORWARD = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ID_WIDTH-1:0]     result_sel,
  output logic [127:0]            result,
  output logic [DATA_WIDTH-1:0]   axis_m_data,
  output logic [DATA_WIDTH/8-1:0] axis_m_keep,
  output logic                    axis_m_last,
  output logic [DATA_WIDTH/8-1:0] axis_m_user,
  output logic [ID_WIDTH-1:0]     axis_m_id,
  output logic                    axis_m_valid,
  input  logic                    axis_m_ready,
  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int NUM_CH = 2 ** ID_WIDTH;
  localparam int SEQ_BEAT = SEQ_BYTE_OFFSET / KW;
  localparam int SEQ_LANE = SEQ_BYTE_OFFSET % KW;
  localparam int CW = $clog2(KW + 1);

  state_t state;
  logic in_frame, cnt_r, err_r, have_r;
  logic [ID_WIDTH-1:0] ch_r;
  logic [15:0] idx_r, bytes_r;
  logic [SEQ_WIDTH-1:0] seq_r;
  logic [FRAMES_W-1:0] frames [NUM_CH];
  logic [BYTES_W-1:0] bytes [NUM_CH];
  logic [SEQERR_W-1:0] seq_err [NUM_CH];
  logic [BAD_W-1:0] bad [NUM_CH];
  logic [SEQ_WIDTH-1:0] expected [NUM_CH];
  logic [NUM_CH-1:0] seen;

  logic [CW-1:0] pop;
  logic hs, end_hs, commit, seq_hit, cur_have, cur_err, cur_cnt;
  logic [ID_WIDTH-1:0] cur_ch;
  logic [15:0] cur_idx, cur_bytes;
  logic [16:0] sum;
  logic [SEQ_WIDTH-1:0] beat_seq, cur_seq;
  logic [BYTES_W:0] bank_bsum;

  keep_popcount #(.KEEP_WIDTH(KW)) u_pop (.keep(axis_s_keep), .count(pop));

  assign axis_s_ready = FORWARD != 0 ? axis_m_ready : 1'b1;
  assign axis_m_valid = FORWARD != 0 && axis_s_valid;
  assign axis_m_data = FORWARD != 0 ? axis_s_data : '0;
  assign axis_m_keep = FORWARD != 0 ? axis_s_keep : '0;
  assign axis_m_last = FORWARD != 0 && axis_s_last;
  assign axis_m_user = FORWARD != 0 ? axis_s_user : '0;
  assign axis_m_id = FORWARD != 0 ? axis_s_id : '0;
  assign ready = state == IDLE;

  // cur_* fold the current beat into the per-frame accumulators, so a
  // first beat (or a single-beat frame) is handled without special cases
  always_comb begin
    beat_seq = '0;
    for (int i = 0; i < 4; i++) beat_seq[SEQ_WIDTH-1-8*i -: 8] = axis_s_data[8*(SEQ_LANE+i) +: 8];
  end
  assign hs = axis_s_valid & axis_s_ready;
  assign end_hs = hs & axis_s_last;
  assign cur_idx = in_frame ? idx_r : '0;
  assign sum = (in_frame ? {1'b0, bytes_r} : 17'd0) + 17'(pop);
  assign cur_bytes = sum[16] ? 16'hffff : sum[15:0];
  assign seq_hit = cur_idx == 16'(SEQ_BEAT);
  assign cur_seq = seq_hit ? beat_seq : seq_r;
  assign cur_have = seq_hit | (in_frame & have_r);
  assign cur_err = (in_frame & err_r) | (|axis_s_user);
  assign cur_ch = in_frame ? ch_r : axis_s_id;
  assign cur_cnt = in_frame ? cnt_r : state == RUNNING;
  assign commit = end_hs & cur_cnt;
  assign bank_bsum = {1'b0, bytes[cur_ch]} + (BYTES_W+1)'(cur_bytes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      in_frame <= 1'b0;
      cnt_r <= 1'b0;
      err_r <= 1'b0;
      have_r <= 1'b0;
      ch_r <= '0;
      idx_r <= '0;
      bytes_r <= '0;
      seq_r <= '0;
      seen <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        frames[c] <= '0;
        bytes[c] <= '0;
        seq_err[c] <= '0;
        bad[c] <= '0;
        expected[c] <= '0;
      end
    end else begin
      result[FRAMES_LSB +: FRAMES_W] <= frames[result_sel];
      result[BYTES_LSB +: BYTES_W] <= bytes[result_sel];
      result[SEQERR_LSB +: SEQERR_W] <= seq_err[result_sel];
      result[BAD_LSB +: BAD_W] <= bad[result_sel];
      if (hs) begin
        in_frame <= !axis_s_last;
        ch_r <= cur_ch;
        cnt_r <= cur_cnt;
        err_r <= cur_err;
        have_r <= cur_have;
        seq_r <= cur_seq;
        bytes_r <= cur_bytes;
        idx_r <= &cur_idx ? cur_idx : cur_idx + 16'd1;
      end
      if (commit) begin
        frames[cur_ch] <= &frames[cur_ch] ? frames[cur_ch] : frames[cur_ch] + FRAMES_W'(1);
        bytes[cur_ch] <= bank_bsum[BYTES_W] ? '1 : bank_bsum[BYTES_W-1:0];
        if (cur_err || !cur_have)
          bad[cur_ch] <= &bad[cur_ch] ? bad[cur_ch] : bad[cur_ch] + BAD_W'(1);
        else begin
          seen[cur_ch] <= 1'b1;
          expected[cur_ch] <= cur_seq + SEQ_WIDTH'(1);
          if (seen[cur_ch] && cur_seq != expected[cur_ch] && !(&seq_err[cur_ch]))
            seq_err[cur_ch] <= seq_err[cur_ch] + SEQERR_W'(1);
        end
      end
      case (state)
        IDLE: if (start && !stop) begin
          state <= RUNNING;
          seen <= '0;
          for (int c = 0; c < NUM_CH; c++) begin
            frames[c] <= '0;
            bytes[c] <= '0;
            seq_err[c] <= '0;
            bad[c] <= '0;
            expected[c] <= '0;
          end
        end
        RUNNING: if (stop) state <= in_frame && !end_hs ? DRAIN : IDLE;
        DRAIN: if (end_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_checker_mc.sv
// tb_frame_checker_mc: random + directed check of frame_checker_mc against a frame-level model.
module tb_frame_checker_mc;
  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mst_t;

  logic clk = 1'b0;
  logic rst_n, start, stop, m_ready;
  logic [2:0] result_sel, s_id, m_id0, m_id1;
  logic [127:0] result0, result1;
  logic ready0, ready1, s_ready0, s_ready1;
  logic [63:0] s_data, m_data0, m_data1;
  logic [7:0] s_keep, s_user, m_keep0, m_keep1, m_user0, m_user1;
  logic s_last, s_valid, m_last0, m_last1, m_valid0, m_valid1, v0;

  int n_tests = 0, n_fail = 0, tmode = 0;
  bit run_flag = 0;
  logic [31:0] nseq [8];

  mst_t mst;
  byte unsigned fq[$];
  int f_pop, f_ch;
  bit f_err, f_cnt;
  logic [31:0] mf [8];
  logic [47:0] mb [8];
  logic [23:0] ms [8], mbad [8];
  logic [31:0] mexp [8];
  bit mseen [8];
  logic [127:0] exp_res;
  bit exp_rdy;

  always #5 clk = ~clk;

  // the sink instance sees valid only when the forwarding instance handshakes,
  // so both observe the identical accepted-beat sequence
  assign v0 = s_valid & m_ready;

  frame_checker_mc #(.FORWARD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ready(ready0), .start(start), .stop(stop),
    .result_sel(result_sel), .result(result0),
    .axis_m_data(m_data0), .axis_m_keep(m_keep0), .axis_m_last(m_last0), .axis_m_user(m_user0),
    .axis_m_id(m_id0), .axis_m_valid(m_valid0), .axis_m_ready(m_ready),
    .axis_s_data(s_data), .axis_s_keep(s_keep), .axis_s_last(s_last), .axis_s_user(s_user),
    .axis_s_id(s_id), .axis_s_valid(v0), .axis_s_ready(s_ready0));

  frame_checker_mc #(.FORWARD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ready(ready1), .start(start), .stop(stop),
    .result_sel(result_sel), .result(result1),
    .axis_m_data(m_data1), .axis_m_keep(m_keep1), .axis_m_last(m_last1), .axis_m_user(m_user1),
    .axis_m_id(m_id1), .axis_m_valid(m_valid1), .axis_m_ready(m_ready),
    .axis_s_data(s_data), .axis_s_keep(s_keep), .axis_s_last(s_last), .axis_s_user(s_user),
    .axis_s_id(s_id), .axis_s_valid(s_valid), .axis_s_ready(s_ready1));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input int c);
    return {mf[c], mb[c], ms[c], mbad[c]};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 8; c++) begin
      mf[c] = 0; mb[c] = 0; ms[c] = 0; mbad[c] = 0; mexp[c] = 0; mseen[c] = 0;
    end
  endtask

  task automatic model_commit();
    longint t;
    logic [31:0] sq;
    mf[f_ch] = mf[f_ch] == 32'hffffffff ? mf[f_ch] : mf[f_ch] + 1;
    t = longint'(mb[f_ch]) + (f_pop > 65535 ? 65535 : f_pop);
    mb[f_ch] = t > 64'hffff_ffff_ffff ? 48'hffff_ffff_ffff : 48'(t);
    if (f_err || fq.size() < 46) mbad[f_ch] = mbad[f_ch] == 24'hffffff ? mbad[f_ch] : mbad[f_ch] + 1;
    else begin
      sq = {fq[42], fq[43], fq[44], fq[45]};
      if (mseen[f_ch] && sq != mexp[f_ch]) ms[f_ch] = ms[f_ch] == 24'hffffff ? ms[f_ch] : ms[f_ch] + 1;
      mseen[f_ch] = 1;
      mexp[f_ch] = sq + 1;
    end
  endtask

  task automatic model_step();
    bit hs;
    mst_t nxt;
    hs = s_valid && m_ready;
    nxt = mst;
    exp_res = pack(int'(result_sel));
    if (mst == M_IDLE && start && !stop) begin nxt = M_RUN; model_clear(); end
    else if (mst == M_RUN && stop) nxt = (fq.size() > 0 && !(hs && s_last)) ? M_DRAIN : M_IDLE;
    else if (mst == M_DRAIN && hs && s_last) nxt = M_IDLE;
    if (hs) begin
      if (fq.size() == 0) begin
        f_ch = int'(s_id); f_cnt = mst == M_RUN; f_pop = 0; f_err = 0;
      end
      for (int k = 0; k < 8; k++) fq.push_back(s_data[8*k +: 8]);
      f_pop += $countones(s_keep);
      f_err |= s_user != 0;
      if (s_last) begin
        if (f_cnt) model_commit();
        fq.delete();
      end
    end
    mst = nxt;
    exp_rdy = mst == M_IDLE;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ready", {ready0, ready1}, 2'b11);
      chk("reset_result0", result0, 0);
      chk("reset_result1", result1, 0);
      model_clear();
      fq.delete();
      mst = M_IDLE; exp_res = 0; exp_rdy = 1;
    end else begin
      chk("ready", {ready0, ready1}, {exp_rdy, exp_rdy});
      chk("result0", result0, exp_res);
      chk("result1", result1, exp_res);
      chk("fwd_stream", {m_valid1, m_data1, m_keep1, m_last1, m_user1, m_id1, s_ready1},
          {s_valid, s_data, s_keep, s_last, s_user, s_id, m_ready});
      chk("sink_stream", {m_valid0, m_data0, m_keep0, m_last0, m_user0, m_id0, s_ready0}, 1);
      model_step();
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = tmode == 0 ? 1'b1 : tmode == 1 ? ~m_ready : 1'($urandom_range(1));
    end
  end

  task automatic pulse(input bit st, input bit sp);
    start = st; stop = sp;
    @(posedge clk);
    #1;
    start = 0; stop = 0;
  endtask

  task automatic send_frame(input int ch, input int nbytes, input logic [31:0] seq, input bit usr,
                            input int stop_b, input int start_b);
    byte unsigned fb[];
    int nb, guard;
    bit acc;
    nb = (nbytes + 7) / 8;
    fb = new[nb * 8];
    foreach (fb[i]) fb[i] = 8'($urandom);
    if (nb * 8 >= 46) {fb[42], fb[43], fb[44], fb[45]} = seq;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 8; k++) s_data[8*k +: 8] = fb[8*b + k];
      s_keep = (b == nb - 1 && nbytes % 8 != 0) ? 8'((1 << (nbytes % 8)) - 1) : 8'hff;
      s_last = b == nb - 1;
      s_user = (usr && b == nb - 1) ? 8'h01 : 8'h00;
      s_id = 3'(ch);
      s_valid = 1;
      stop = b == stop_b;
      start = b == start_b;
      guard = 0;
      do begin
        @(posedge clk);
        acc = m_ready;
        #1;
        stop = 0; start = 0;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("handshake_timeout", 0, 1);
      if (b == stop_b) chk("drain_ready", ready1, 0);
      if (!s_last && $urandom_range(4) == 0) begin
        s_valid = 0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 0; s_last = 0; s_user = 0;
  endtask

  task automatic read_ch(input int c, input logic [127:0] exp, input string nm);
    result_sel = 3'(c);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk({nm, "_dut0"}, result0, exp);
    chk({nm, "_dut1"}, result1, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int ch, len, sb, r;
    logic [31:0] sq;
    rst_n = 0; start = 0; stop = 0; result_sel = 0;
    s_data = 0; s_keep = 0; s_last = 0; s_user = 0; s_id = 0; s_valid = 0;
    foreach (nseq[i]) nseq[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("post_reset_ready", ready1, 1);
    chk("post_reset_result", result1, 0);

    pulse(1, 0); run_flag = 1;
    for (int i = 5; i <= 7; i++) send_frame(2, 64, i, 0, -1, -1);
    send_frame(1, 64, 10, 0, -1, -1);
    send_frame(1, 64, 11, 0, -1, -1);
    send_frame(1, 64, 13, 0, -1, -1);
    send_frame(1, 64, 12, 0, -1, -1);
    send_frame(3, 64, 32'hffffffff, 0, -1, -1);
    send_frame(3, 64, 0, 0, -1, -1);
    send_frame(4, 60, 100, 0, -1, -1);
    send_frame(4, 64, 101, 1, -1, -1);
    send_frame(6, 40, 0, 0, -1, -1);
    pulse(0, 1); run_flag = 0;
    read_ch(2, {32'd3, 48'd192, 24'd0, 24'd0}, "ch2_seq_ok");
    read_ch(0, 128'd0, "ch0_idle");
    read_ch(1, {32'd4, 48'd256, 24'd2, 24'd0}, "ch1_seq_err");
    read_ch(3, {32'd2, 48'd128, 24'd0, 24'd0}, "ch3_seq_wrap");
    read_ch(4, {32'd2, 48'd124, 24'd0, 24'd1}, "ch4_keep_user");
    read_ch(6, {32'd1, 48'd40, 24'd0, 24'd1}, "ch6_short");

    pulse(1, 0);
    send_frame(5, 64, 1, 0, 3, -1);
    chk("drain_done_ready", ready1, 1);
    read_ch(5, {32'd1, 48'd64, 24'd0, 24'd0}, "ch5_drained");
    send_frame(5, 64, 2, 0, -1, 2);
    read_ch(5, 128'd0, "ch5_start_mid");
    send_frame(5, 64, 9, 0, -1, -1);
    read_ch(5, {32'd1, 48'd64, 24'd0, 24'd0}, "ch5_after_start");
    pulse(0, 1);
    pulse(1, 1);
    chk("start_stop_idle", ready1, 1);
    pulse(1, 0); run_flag = 1;
    send_frame(5, 65600, 77, 0, -1, -1);
    read_ch(5, {32'd1, 48'd65535, 24'd0, 24'd0}, "ch5_bytes_sat");

    for (int f = 0; f < 200; f++) begin
      ch = $urandom_range(7);
      len = $urandom_range(1, 100);
      sb = -1;
      tmode = $urandom_range(2);
      sq = $urandom_range(5) == 0 ? $urandom : nseq[ch];
      nseq[ch] = sq + 1;
      if (run_flag && len > 16 && $urandom_range(11) == 0) begin
        sb = $urandom_range(1, (len + 7) / 8 - 2);
        run_flag = 0;
      end
      send_frame(ch, len, sq, $urandom_range(9) == 0, sb, -1);
      result_sel = 3'($urandom_range(7));
      r = $urandom_range(19);
      if (run_flag && r == 0) begin pulse(0, 1); run_flag = 0; end
      else if (!run_flag && r < 8) begin pulse(1, 0); run_flag = 1; end
      else if (r == 19) begin pulse(1, 0); run_flag = 1; end
    end

    tmode = 0;
    @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      s_data = {$urandom, $urandom}; s_keep = 8'hff; s_last = 0; s_user = 0; s_id = 3; s_valid = 1;
      @(posedge clk);
      #1;
    end
    #1 rst_n = 0;
    #1;
    chk("async_reset_ready", {ready0, ready1}, 2'b11);
    chk("async_reset_result", {result0, result1}, 0);
    s_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    pulse(1, 0);
    send_frame(7, 64, 3, 0, -1, -1);
    read_ch(7, {32'd1, 48'd64, 24'd0, 24'd0}, "ch7_after_reset");
    read_ch(3, 128'd0, "ch3_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
